// File: rtl/xfer_ctrl.sv
// Command sequencer for the register_xfer block: turns one accepted command into
// a timed sequence of active-low, flop-driven bus strobes with a done pulse.
module xfer_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_op,
  input  logic [2:0] cmd_len,
  output logic       cmd_ready,
  output logic       busy,
  output logic       done,
  output logic       hi_byte,
  output logic       assert_addr,
  output logic       assert_xfer,
  output logic       load_xfer,
  output logic       assertlow_main,
  output logic       asserthigh_main,
  output logic       loadlow_main,
  output logic       loadhigh_main
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP0,
    S_STEP1,
    S_HOLD,
    S_TURN
  } state_t;

  typedef enum logic [1:0] {
    OP_LOAD_MAIN16  = 2'd0,
    OP_STORE_MAIN16 = 2'd1,
    OP_LOAD_XFER    = 2'd2,
    OP_ADDR_OUT     = 2'd3
  } op_t;

  typedef struct packed {
    logic assert_addr;
    logic assert_xfer;
    logic load_xfer;
    logic assertlow_main;
    logic asserthigh_main;
    logic loadlow_main;
    logic loadhigh_main;
  } strobes_t;

  localparam strobes_t STROBES_IDLE = '1;

  state_t   state_q, state_d;
  op_t      op_q, op_d;
  logic [2:0] cnt_q, cnt_d;
  logic     done_q, done_d;
  logic     hi_q, hi_d;
  strobes_t strb_q, strb_d;

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d = op_t'(cmd_op);
          if (op_d == OP_ADDR_OUT) begin
            state_d = S_HOLD;
            cnt_d   = cmd_len;
          end else begin
            state_d = S_STEP0;
          end
        end
      end
      S_STEP0: begin
        if (op_q == OP_LOAD_XFER) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_STEP1;
        end
      end
      S_STEP1: begin
        done_d  = 1'b1;
        state_d = (op_q == OP_STORE_MAIN16) ? S_TURN : S_IDLE;
      end
      S_HOLD: begin
        if (cnt_q == 3'd0) begin
          state_d = S_TURN;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_TURN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Strobes are decoded from the next state so they register in step with it.
    strb_d = STROBES_IDLE;
    hi_d   = 1'b0;
    case (state_d)
      S_STEP0: begin
        case (op_d)
          OP_LOAD_MAIN16:  strb_d.loadlow_main   = 1'b0;
          OP_STORE_MAIN16: strb_d.assertlow_main = 1'b0;
          OP_LOAD_XFER:    strb_d.load_xfer      = 1'b0;
          default:         ;
        endcase
      end
      S_STEP1: begin
        hi_d = 1'b1;
        if (op_d == OP_STORE_MAIN16) strb_d.asserthigh_main = 1'b0;
        else                         strb_d.loadhigh_main   = 1'b0;
      end
      S_HOLD:  strb_d.assert_addr = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_LOAD_MAIN16;
      cnt_q   <= 3'd0;
      done_q  <= 1'b0;
      hi_q    <= 1'b0;
      strb_q  <= STROBES_IDLE;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      strb_q  <= strb_d;
    end
  end

  assign cmd_ready       = (state_q == S_IDLE);
  assign busy            = (state_q != S_IDLE);
  assign done            = done_q;
  assign hi_byte         = hi_q;
  assign assert_addr     = strb_q.assert_addr;
  assign assert_xfer     = strb_q.assert_xfer;
  assign load_xfer       = strb_q.load_xfer;
  assign assertlow_main  = strb_q.assertlow_main;
  assign asserthigh_main = strb_q.asserthigh_main;
  assign loadlow_main    = strb_q.loadlow_main;
  assign loadhigh_main   = strb_q.loadhigh_main;

endmodule

// File: tb/tb_xfer_ctrl.sv
// Self-checking bench for xfer_ctrl: a per-command frame-queue model checked every
// cycle, plus directed literal checks of the documented timing cases.
module tb_xfer_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [2:0] cmd_len;
  logic       cmd_ready, busy, done, hi_byte;
  logic       assert_addr, assert_xfer, load_xfer;
  logic       assertlow_main, asserthigh_main, loadlow_main, loadhigh_main;

  always #5 clk = ~clk;

  xfer_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_op          (cmd_op),
    .cmd_len         (cmd_len),
    .cmd_ready       (cmd_ready),
    .busy            (busy),
    .done            (done),
    .hi_byte         (hi_byte),
    .assert_addr     (assert_addr),
    .assert_xfer     (assert_xfer),
    .load_xfer       (load_xfer),
    .assertlow_main  (assertlow_main),
    .asserthigh_main (asserthigh_main),
    .loadlow_main    (loadlow_main),
    .loadhigh_main   (loadhigh_main)
  );

  // Strobe bit positions inside strb_n (active low).
  localparam int B_ADDR = 6, B_AXFER = 5, B_LXFER = 4, B_ALOW = 3, B_AHIGH = 2, B_LLOW = 1, B_LHIGH = 0;

  typedef struct packed {
    logic       cmd_ready;
    logic       busy;
    logic       done;
    logic       hi_byte;
    logic [6:0] strb_n;
  } frame_t;

  frame_t dut_f;
  assign dut_f = {cmd_ready, busy, done, hi_byte, assert_addr, assert_xfer, load_xfer,
                  assertlow_main, asserthigh_main, loadlow_main, loadhigh_main};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic frame_t mk(input bit rdy, input bit bsy, input bit dn, input bit hi, input int low_idx);
    frame_t f;
    f.cmd_ready = rdy;
    f.busy      = bsy;
    f.done      = dn;
    f.hi_byte   = hi;
    f.strb_n    = 7'h7F;
    if (low_idx >= 0) f.strb_n[low_idx] = 1'b0;
    return f;
  endfunction

  // Model: each accepted command expands into the list of cycles it must produce.
  frame_t exp_q[$];
  frame_t cur;
  bit     model_ok = 0;
  int     acc_cnt  = 0;
  int     done_cnt = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        exp_q.delete();
        cur      = mk(1, 0, 0, 0, -1);
        model_ok = 1;
      end else if (model_ok) begin
        if (cur.cmd_ready && cmd_valid) begin
          acc_cnt++;
          case (cmd_op)
            2'd0: begin
              exp_q.push_back(mk(0, 1, 0, 0, B_LLOW));
              exp_q.push_back(mk(0, 1, 0, 1, B_LHIGH));
              exp_q.push_back(mk(1, 0, 1, 0, -1));
            end
            2'd1: begin
              exp_q.push_back(mk(0, 1, 0, 0, B_ALOW));
              exp_q.push_back(mk(0, 1, 0, 1, B_AHIGH));
              exp_q.push_back(mk(0, 1, 1, 0, -1));
            end
            2'd2: begin
              exp_q.push_back(mk(0, 1, 0, 0, B_LXFER));
              exp_q.push_back(mk(1, 0, 1, 0, -1));
            end
            default: begin
              for (int i = 0; i <= int'(cmd_len); i++) exp_q.push_back(mk(0, 1, 0, 0, B_ADDR));
              exp_q.push_back(mk(0, 1, 1, 0, -1));
            end
          endcase
        end
        cur = (exp_q.size() != 0) ? exp_q.pop_front() : mk(1, 0, 0, 0, -1);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (model_ok) begin
        check("frame", dut_f, cur);
        check("one_strobe_low", ($countones(~dut_f.strb_n) <= 1), 1);
        if (done) done_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic wait_ready();
    int k = 0;
    while (!cmd_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) check("ready_timeout", 0, 1);
  endtask

  // Returns at the falling edge inside the first cycle after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [2:0] len);
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic addr_run(input logic [2:0] len, input int exp_cycles);
    int cnt = 0;
    int k   = 0;
    issue(2'd3, len);
    while (assert_addr == 1'b0 && k < 12) begin
      cnt++;
      k++;
      @(negedge clk);
    end
    check("addr_low_cycles", cnt, exp_cycles);
    check("addr_turn_done", done, 1);
    check("addr_turn_ready", cmd_ready, 0);
    check("addr_turn_strobes", dut_f.strb_n, 7'h7F);
  endtask

  initial begin
    int acc_base, done_base;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_len   = 3'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_frame", dut_f, 11'h47F);

    // LOAD_MAIN16 timing
    issue(2'd0, 3'd0);
    check("lm_loadlow", loadlow_main, 0);
    check("lm_hi0", hi_byte, 0);
    @(negedge clk);
    check("lm_loadhigh", loadhigh_main, 0);
    check("lm_hi1", hi_byte, 1);
    @(negedge clk);
    check("lm_done", done, 1);
    check("lm_ready", cmd_ready, 1);

    // STORE_MAIN16 then LOAD_XFER with cmd_valid held high
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op    = 2'd1;
    @(negedge clk);
    cmd_op = 2'd2;
    check("st_assertlow", assertlow_main, 0);
    @(negedge clk);
    check("st_asserthigh", asserthigh_main, 0);
    check("st_hi1", hi_byte, 1);
    @(negedge clk);
    check("st_turn_done", done, 1);
    check("st_turn_ready", cmd_ready, 0);
    @(negedge clk);
    check("st_idle_ready", cmd_ready, 1);
    check("st_idle_strobes", dut_f.strb_n, 7'h7F);
    @(negedge clk);
    check("lx_load_xfer", load_xfer, 0);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("lx_done", done, 1);
    check("lx_released", load_xfer, 1);

    // ADDR_OUT length extremes
    addr_run(3'd7, 8);
    addr_run(3'd0, 1);

    // Reset in the third hold cycle of ADDR_OUT len 5
    issue(2'd3, 3'd5);
    @(negedge clk);
    @(negedge clk);
    check("abort_hold3", assert_addr, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_addr_high", assert_addr, 1);
    check("abort_idle", busy, 0);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end
    issue(2'd2, 3'd0);
    check("abort_next_cmd", load_xfer, 0);
    @(negedge clk);

    // Reset wins over a simultaneous command
    wait_ready();
    reset     = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = 2'd0;
    @(negedge clk);
    reset     = 1'b0;
    cmd_valid = 1'b0;
    check("rst_drop_busy", busy, 0);
    check("rst_drop_strobes", dut_f.strb_n, 7'h7F);

    // Random command stream
    acc_base  = acc_cnt;
    done_base = done_cnt;
    for (int i = 0; i < 400; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_len   = 3'($urandom_range(0, 7));
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("rand_done_per_accept", done_cnt - done_base, acc_cnt - acc_base);
    check("rand_assert_xfer", assert_xfer, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
